router_scheduler: RTL and testbench

Packet scheduler that shares the single input of the 4-port `simple_router` between `NUM_REQ` upstream requesters. It grants one requester at a time with round-robin fairness and holds the grant for a whole packet, so beats from different sources never interleave. It also stalls beats while the locked destination port is not ready. Outputs drive the router's `din`, `din_en` and `addr` directly from registers.

---
 rtl/router_pkg.sv | 13 +
 rtl/router_scheduler_rr_arbiter.sv | 29 ++
 rtl/router_scheduler.sv | 113 +++++++++++
 tb/tb_router_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router types and constants.
// Used by the scheduler and its arbiter.
package router_pkg;

   localparam int ROUTER_PORTS  = 4;
   localparam int ROUTER_ADDR_W = 2;

   typedef enum logic {
      IDLE,
      XFER
   } sched_state_t;

endpackage

// File: rtl/router_scheduler_rr_arbiter.sv
// Rotating-priority request picker.
// The search starts just after ptr and wraps around.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_vld
);

   int idx;

   // Walk from farthest to nearest so the nearest set bit wins
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            gnt_idx = IW'(idx);
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_scheduler.sv
// Packet-locked round-robin scheduler feeding
// the single input of the 4-port router.
module router_scheduler
   import router_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_REQ    = 4,
   parameter  int MAX_BEATS  = 16,
   localparam int GW         = $clog2(NUM_REQ),
   localparam int CW         = $clog2(MAX_BEATS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ*2-1:0]          req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [ROUTER_PORTS-1:0]       dest_ready,
   output logic [DATA_WIDTH-1:0]         din,
   output logic                          din_en,
   output logic [ROUTER_ADDR_W-1:0]      addr,
   output logic [GW-1:0]                 grant_id,
   output logic                          busy,
   output logic                          trunc_err
);

   sched_state_t             state;
   logic [ROUTER_ADDR_W-1:0] lock_addr;
   logic [CW-1:0]            beat_cnt;
   logic [GW-1:0]            rr_ptr;

   logic [GW-1:0]            arb_idx;
   logic                     arb_vld;
   logic [ROUTER_ADDR_W-1:0] arb_addr;
   logic                     accept;
   logic                     sel_last;
   logic [DATA_WIDTH-1:0]    sel_data;
   logic                     at_limit;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   // Only the owner sees ready, and only when its port can take data
   always_comb begin
      req_ready = '0;
      if (state == XFER)
         req_ready[grant_id] = dest_ready[lock_addr];
   end

   // Owner beat selection and accept qualification
   always_comb begin
      sel_data = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      sel_last = req_last[grant_id];
      arb_addr = req_addr[int'(arb_idx)*2 +: 2];
      accept   = (state == XFER)
               & req_valid[grant_id]
               & req_ready[grant_id];
      at_limit = (beat_cnt == CW'(MAX_BEATS - 1));
   end

   // Arbitration FSM with registered router-side outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         din       <= '0;
         din_en    <= 1'b0;
         addr      <= '0;
         grant_id  <= '0;
         busy      <= 1'b0;
         trunc_err <= 1'b0;
         beat_cnt  <= '0;
         lock_addr <= '0;
         rr_ptr    <= GW'(NUM_REQ - 1);
      end else begin
         din_en    <= accept;
         din       <= accept ? sel_data : '0;
         trunc_err <= 1'b0;
         if (accept)
            addr <= lock_addr;
         unique case (state)
            IDLE: begin
               if (arb_vld) begin
                  grant_id  <= arb_idx;
                  lock_addr <= arb_addr;
                  beat_cnt  <= '0;
                  busy      <= 1'b1;
                  state     <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (sel_last || at_limit) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     rr_ptr    <= grant_id;
                     trunc_err <= ~sel_last;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_router_scheduler.sv
// Directed bench for router_scheduler.
// Runs with MAX_BEATS=4 so truncation is reachable.
module tb_router_scheduler;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_last;
   logic [127:0] req_data;
   logic [7:0]   req_addr;
   logic [3:0]   req_ready;
   logic [3:0]   dest_ready;
   logic [31:0]  din;
   logic         din_en;
   logic [1:0]   addr;
   logic [1:0]   grant_id;
   logic         busy;
   logic         trunc_err;

   int total = 0;
   int bad   = 0;

   router_scheduler #(
      .DATA_WIDTH (32),
      .NUM_REQ    (4),
      .MAX_BEATS  (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_data   (req_data),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .dest_ready (dest_ready),
      .din        (din),
      .din_en     (din_en),
      .addr       (addr),
      .grant_id   (grant_id),
      .busy       (busy),
      .trunc_err  (trunc_err)
   );

   always #5 clk = ~clk;

   // Per-cycle invariants
   always @(negedge clk) begin
      total++;
      if (!$onehot0(req_ready)) begin
         bad++;
         $display("FAIL ready_onehot: got %b want one-hot or zero", req_ready);
      end
      total++;
      if (!din_en && din !== 32'h0) begin
         bad++;
         $display("FAIL din_zero: got din=%h want 0 while din_en=0", din);
      end
   end

   task automatic test_reset;
      rst        = 1'b0;
      req_valid  = '0;
      req_last   = '0;
      req_data   = '0;
      req_addr   = '0;
      dest_ready = 4'hF;
      repeat (2) @(negedge clk);
      total++;
      if ({din_en, addr, din} !== 35'h0) begin
         bad++;
         $display("FAIL reset_out: got %h want 0", {din_en, addr, din});
      end
      total++;
      if ({busy, grant_id, trunc_err, req_ready} !== 8'h0) begin
         bad++;
         $display("FAIL reset_ctl: got %h want 0",
                  {busy, grant_id, trunc_err, req_ready});
      end
      rst = 1'b1;
   endtask

   task automatic test_single;
      req_valid          = 4'b0001;
      req_last           = 4'b0001;
      req_addr[1:0]      = 2'd2;
      req_data[31:0]     = 32'hA5A5_0001;
      @(negedge clk);
      total++;
      if ({busy, grant_id, req_ready} !== {1'b1, 2'd0, 4'b0001}) begin
         bad++;
         $display("FAIL single_grant: got %h want %h",
                  {busy, grant_id, req_ready}, {1'b1, 2'd0, 4'b0001});
      end
      @(negedge clk);
      req_valid = '0;
      total++;
      if ({busy, din_en, addr, din} !== {1'b0, 1'b1, 2'd2, 32'hA5A5_0001}) begin
         bad++;
         $display("FAIL single_beat: got %h want %h",
                  {busy, din_en, addr, din}, {1'b0, 1'b1, 2'd2, 32'hA5A5_0001});
      end
      @(negedge clk);
      total++;
      if ({busy, din_en, addr, din} !== {1'b0, 1'b0, 2'd2, 32'h0}) begin
         bad++;
         $display("FAIL single_after: got %h want %h",
                  {busy, din_en, addr, din}, {1'b0, 1'b0, 2'd2, 32'h0});
      end
   endtask

   task automatic test_round_robin;
      logic [1:0]  e;
      logic [31:0] d;
      req_valid = 4'hF;
      req_last  = 4'hF;
      for (int i = 0; i < 4; i++) begin
         req_data[i*32 +: 32] = 32'h1000_0000 + i;
         req_addr[i*2 +: 2]   = 2'(i);
      end
      for (int p = 0; p < 5; p++) begin
         e = 2'(p % 4);
         d = 32'h1000_0000 + 32'(p % 4);
         @(negedge clk);
         total++;
         if ({busy, grant_id, din_en} !== {1'b1, e, 1'b0}) begin
            bad++;
            $display("FAIL rr_grant%0d: got %h want %h",
                     p, {busy, grant_id, din_en}, {1'b1, e, 1'b0});
         end
         total++;
         if (req_ready !== (4'b0001 << e)) begin
            bad++;
            $display("FAIL rr_ready%0d: got %b want %b",
                     p, req_ready, 4'b0001 << e);
         end
         @(negedge clk);
         total++;
         if ({busy, din_en, addr, din} !== {1'b0, 1'b1, e, d}) begin
            bad++;
            $display("FAIL rr_beat%0d: got %h want %h",
                     p, {busy, din_en, addr, din}, {1'b0, 1'b1, e, d});
         end
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure;
      req_valid        = 4'b0110;
      req_last         = 4'b0100;
      req_addr[3:2]    = 2'd3;
      req_addr[5:4]    = 2'd0;
      req_data[63:32]  = 32'hB000_0000;
      req_data[95:64]  = 32'hC000_0002;
      @(negedge clk);
      total++;
      if ({busy, grant_id, req_ready} !== {1'b1, 2'd1, 4'b0010}) begin
         bad++;
         $display("FAIL bp_grant: got %h want %h",
                  {busy, grant_id, req_ready}, {1'b1, 2'd1, 4'b0010});
      end
      @(negedge clk);
      total++;
      if ({din_en, addr, din} !== {1'b1, 2'd3, 32'hB000_0000}) begin
         bad++;
         $display("FAIL bp_beat0: got %h want %h",
                  {din_en, addr, din}, {1'b1, 2'd3, 32'hB000_0000});
      end
      req_data[63:32] = 32'hB000_0001;
      dest_ready      = 4'b0111;
      #1;
      total++;
      if (req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL bp_ready_low: got %b want 0000", req_ready);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if ({req_ready, din_en, addr, din} !== {4'b0, 1'b0, 2'd3, 32'h0}) begin
            bad++;
            $display("FAIL bp_stall%0d: got %h want %h",
                     c, {req_ready, din_en, addr, din}, {4'b0, 1'b0, 2'd3, 32'h0});
         end
      end
      dest_ready = 4'hF;
      #1;
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL bp_ready_high: got %b want 0010", req_ready);
      end
      @(negedge clk);
      total++;
      if ({din_en, din} !== {1'b1, 32'hB000_0001}) begin
         bad++;
         $display("FAIL bp_beat1: got %h want %h",
                  {din_en, din}, {1'b1, 32'hB000_0001});
      end
      req_data[63:32] = 32'hB000_0002;
      req_last[1]     = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, din_en, din} !== {1'b0, 1'b1, 32'hB000_0002}) begin
         bad++;
         $display("FAIL bp_beat2: got %h want %h",
                  {busy, din_en, din}, {1'b0, 1'b1, 32'hB000_0002});
      end
      req_valid[1] = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, grant_id, din_en} !== {1'b1, 2'd2, 1'b0}) begin
         bad++;
         $display("FAIL bp_next_grant: got %h want %h",
                  {busy, grant_id, din_en}, {1'b1, 2'd2, 1'b0});
      end
      @(negedge clk);
      total++;
      if ({din_en, addr, din} !== {1'b1, 2'd0, 32'hC000_0002}) begin
         bad++;
         $display("FAIL bp_req2_beat: got %h want %h",
                  {din_en, addr, din}, {1'b1, 2'd0, 32'hC000_0002});
      end
      req_valid = '0;
      req_last  = '0;
   endtask

   task automatic test_truncate;
      logic [31:0] b;
      req_valid       = 4'b0011;
      req_last        = 4'b0010;
      req_addr[1:0]   = 2'd2;
      req_addr[3:2]   = 2'd1;
      req_data[31:0]  = 32'hD000_0000;
      req_data[63:32] = 32'hE000_0001;
      @(negedge clk);
      total++;
      if ({busy, grant_id} !== {1'b1, 2'd0}) begin
         bad++;
         $display("FAIL tr_grant: got %h want %h", {busy, grant_id}, {1'b1, 2'd0});
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         b = 32'hD000_0000 + 32'(k);
         total++;
         if ({din_en, addr, din} !== {1'b1, 2'd2, b}) begin
            bad++;
            $display("FAIL tr_beat%0d: got %h want %h",
                     k, {din_en, addr, din}, {1'b1, 2'd2, b});
         end
         total++;
         if ({trunc_err, busy} !== {k == 3, k != 3}) begin
            bad++;
            $display("FAIL tr_flag%0d: got %b want %b",
                     k, {trunc_err, busy}, {k == 3, k != 3});
         end
         req_data[31:0] = b + 32'h1;
      end
      @(negedge clk);
      total++;
      if ({trunc_err, busy, grant_id, din_en} !== {1'b0, 1'b1, 2'd1, 1'b0}) begin
         bad++;
         $display("FAIL tr_other_grant: got %h want %h",
                  {trunc_err, busy, grant_id, din_en}, {1'b0, 1'b1, 2'd1, 1'b0});
      end
      @(negedge clk);
      total++;
      if ({din_en, addr, din} !== {1'b1, 2'd1, 32'hE000_0001}) begin
         bad++;
         $display("FAIL tr_other_beat: got %h want %h",
                  {din_en, addr, din}, {1'b1, 2'd1, 32'hE000_0001});
      end
      req_valid[1] = 1'b0;
      req_last[1]  = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, grant_id} !== {1'b1, 2'd0}) begin
         bad++;
         $display("FAIL tr_regrant: got %h want %h", {busy, grant_id}, {1'b1, 2'd0});
      end
      @(negedge clk);
      total++;
      if ({din_en, din} !== {1'b1, 32'hD000_0004}) begin
         bad++;
         $display("FAIL tr_beat4: got %h want %h",
                  {din_en, din}, {1'b1, 32'hD000_0004});
      end
      req_data[31:0] = 32'hD000_0005;
      req_last[0]    = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, trunc_err, din_en, din} !== {1'b0, 1'b0, 1'b1, 32'hD000_0005}) begin
         bad++;
         $display("FAIL tr_beat5: got %h want %h",
                  {busy, trunc_err, din_en, din}, {1'b0, 1'b0, 1'b1, 32'hD000_0005});
      end
      req_valid = '0;
      req_last  = '0;
   endtask

   task automatic test_mid_reset;
      req_valid       = 4'b0011;
      req_last        = 4'b0001;
      req_addr[1:0]   = 2'd1;
      req_addr[3:2]   = 2'd3;
      req_data[31:0]  = 32'h7700_0000;
      req_data[63:32] = 32'hF000_0000;
      @(negedge clk);
      total++;
      if ({busy, grant_id} !== {1'b1, 2'd1}) begin
         bad++;
         $display("FAIL mr_grant: got %h want %h", {busy, grant_id}, {1'b1, 2'd1});
      end
      @(negedge clk);
      req_data[63:32] = 32'hF000_0001;
      @(negedge clk);
      total++;
      if ({din_en, addr, din} !== {1'b1, 2'd3, 32'hF000_0001}) begin
         bad++;
         $display("FAIL mr_beat2: got %h want %h",
                  {din_en, addr, din}, {1'b1, 2'd3, 32'hF000_0001});
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if ({busy, din_en, grant_id, addr, din, req_ready} !== 41'h0) begin
         bad++;
         $display("FAIL mr_async: got %h want 0",
                  {busy, din_en, grant_id, addr, din, req_ready});
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, grant_id} !== {1'b1, 2'd0}) begin
         bad++;
         $display("FAIL mr_first_grant: got %h want %h",
                  {busy, grant_id}, {1'b1, 2'd0});
      end
      @(negedge clk);
      total++;
      if ({din_en, addr, din} !== {1'b1, 2'd1, 32'h7700_0000}) begin
         bad++;
         $display("FAIL mr_beat: got %h want %h",
                  {din_en, addr, din}, {1'b1, 2'd1, 32'h7700_0000});
      end
      req_valid = '0;
      req_last  = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_reset();
      test_round_robin();
      test_reset();
      test_backpressure();
      test_reset();
      test_truncate();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
